// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave word RAM with a fixed number of waitrequest stall cycles per access,
// a sticky error flag for out-of-range accesses, completed-access counters and a preload port.
module avalon_wait_ram #(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q;
    logic [15:0] rd_count_q, wr_count_q;
    logic [31:0] mem_q [DEPTH];

    logic [29:0]   bus_word, load_word;
    logic [AW-1:0] bus_ptr, load_ptr;
    logic          bus_in_range, load_ok;
    logic          req, complete, bus_ok, rd_ok, wr_ok, bus_bad;

    // Word index uses modular subtraction, so addresses below the base wrap high and fail the range test.
    assign bus_word     = 30'((address - BASE_ADDR) >> 2);
    assign load_word    = 30'((load_addr - BASE_ADDR) >> 2);
    assign bus_ptr      = bus_word[AW-1:0];
    assign load_ptr     = load_word[AW-1:0];
    assign bus_in_range = (bus_word < 30'(DEPTH)) && (address[1:0] == 2'b00);
    assign load_ok      = load_en && (load_word < 30'(DEPTH)) && (load_addr[1:0] == 2'b00);

    assign req = read | write;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waitrequest = 1'b0;
        complete    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WC == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        state_d     = WAIT;
                        cnt_d       = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q < WC) begin
                    waitrequest = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (reset) begin
            waitrequest = 1'b0;
            complete    = 1'b0;
        end
    end

    // Both strobes high completes the stall but is treated like an out-of-range access.
    assign bus_ok  = complete && (read ^ write) && bus_in_range;
    assign rd_ok   = bus_ok && read;
    assign wr_ok   = bus_ok && write;
    assign bus_bad = complete && !bus_ok;

    assign readdata = rd_ok ? mem_q[bus_ptr] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            rd_count_q <= 16'h0;
            wr_count_q <= 16'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_q | bus_bad;
            rd_count_q <= rd_count_q + 16'(rd_ok);
            wr_count_q <= wr_count_q + 16'(wr_ok);
        end
    end

    // No reset on the array; the load assignment comes last so it overrides a bus write to the same word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem_q[bus_ptr][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
        if (load_ok) begin
            mem_q[load_ptr] <= load_data;
        end
    end

    assign err      = err_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Three RAM instances (0, 3 and 2 stall cycles) driven independently and checked against a word-level model.
module tb_avalon_wait_ram;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s    [3];
    logic [31:0] addr_s   [3];
    logic [3:0]  be_s     [3];
    logic        rd_s     [3];
    logic        wr_s     [3];
    logic [31:0] wd_s     [3];
    logic [31:0] rdata_s  [3];
    logic        wait_s   [3];
    logic        ld_s     [3];
    logic [31:0] ldaddr_s [3];
    logic [31:0] lddata_s [3];
    logic        err_s    [3];
    logic [15:0] rdc_s    [3];
    logic [15:0] wrc_s    [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            avalon_wait_ram #(
                .DEPTH      (256),
                .BASE_ADDR  (BASE),
                .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
            ) u_dut (
                .clk        (clk),
                .reset      (rst_s[g]),
                .address    (addr_s[g]),
                .byteenable (be_s[g]),
                .read       (rd_s[g]),
                .write      (wr_s[g]),
                .writedata  (wd_s[g]),
                .readdata   (rdata_s[g]),
                .waitrequest(wait_s[g]),
                .load_en    (ld_s[g]),
                .load_addr  (ldaddr_s[g]),
                .load_data  (lddata_s[g]),
                .err        (err_s[g]),
                .rd_count   (rdc_s[g]),
                .wr_count   (wrc_s[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    logic [31:0] mm  [3][256];
    int          rdm [3];
    int          wrm [3];
    bit          errm[3];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl[12];

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 4 < 256) && (a % 4 == 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    task automatic idle_in(input int k);
        rd_s[k]   = 1'b0;
        wr_s[k]   = 1'b0;
        addr_s[k] = 32'h0;
        be_s[k]   = 4'h0;
        wd_s[k]   = 32'h0;
    endtask

    task automatic chk_state(input int k, input string tag);
        chk($sformatf("%s_rd_count_k%0d", tag, k), 32'(rdc_s[k]), 32'(16'(rdm[k])));
        chk($sformatf("%s_wr_count_k%0d", tag, k), 32'(wrc_s[k]), 32'(16'(wrm[k])));
        chk($sformatf("%s_err_k%0d", tag, k), 32'(err_s[k]), 32'(errm[k]));
    endtask

    // Entered and left at posedge+1; one full access with per-cycle waitrequest checks.
    task automatic do_access(input int k, input bit r, input bit w, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d, output logic [31:0] got);
        bit          ok;
        int          idx;
        logic [31:0] exp_rd;
        ok     = (r ^ w) && in_rng(a);
        idx    = ok ? widx(a) : 0;
        exp_rd = (ok && r) ? mm[k][idx] : 32'h0;
        addr_s[k] = a;
        be_s[k]   = be;
        wd_s[k]   = d;
        rd_s[k]   = r;
        wr_s[k]   = w;
        got       = 32'h0;
        for (int c = 0; c <= wc(k); c++) begin
            @(negedge clk);
            chk($sformatf("waitrequest_k%0d_cyc%0d", k, c), 32'(wait_s[k]), 32'(c < wc(k)));
            if (c == wc(k)) begin
                got = rdata_s[k];
                chk($sformatf("readdata_k%0d_a%08h", k, a), rdata_s[k], exp_rd);
            end
            @(posedge clk);
            #1;
        end
        idle_in(k);
        if (ok && r) rdm[k]++;
        if (ok && w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
            wrm[k]++;
        end
        if (!ok) errm[k] = 1'b1;
        chk_state(k, "post_access");
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] d;
        logic [31:0] a;
        bit          r, w;

        tbl[0]  = '{1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h0,        32'h240ABFC0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'hBFC00008, 4'hF, 32'h12345678, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0,        32'h12345678, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'hBFC00008, 4'h8, 32'hAA000000, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0,        32'hAA345678, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'hBFC00008, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0,        32'hAA345678, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'hBFC003FC, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'hBFC003FC, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0,        32'h0,        1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'hBFC00002, 4'hF, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'hBFC00008, 4'hF, 32'h55555555, 32'h0,        1'b1};

        for (int k = 0; k < 3; k++) begin
            rst_s[k]    = 1'b1;
            ld_s[k]     = 1'b0;
            ldaddr_s[k] = 32'h0;
            lddata_s[k] = 32'h0;
            idle_in(k);
            rdm[k]  = 0;
            wrm[k]  = 0;
            errm[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Preload through the load port while reset is held, with live requests that must stay invisible.
        rd_s[0] = 1'b1; addr_s[0] = BASE;
        wr_s[1] = 1'b1; addr_s[1] = BASE; be_s[1] = 4'hF; wd_s[1] = 32'hFFFFFFFF;
        for (int wi = 0; wi < 256; wi++) begin
            d = $urandom;
            for (int k = 0; k < 3; k++) begin
                ld_s[k]     = 1'b1;
                ldaddr_s[k] = BASE + 32'(wi * 4);
                lddata_s[k] = d;
            end
            if (wi == 5) begin
                @(negedge clk);
                chk("reset_readdata_k0", rdata_s[0], 32'h0);
                chk("reset_wait_k0", 32'(wait_s[0]), 32'h0);
                chk("reset_wait_k1", 32'(wait_s[1]), 32'h0);
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) mm[k][wi] = d;
        end
        for (int k = 0; k < 3; k++) begin
            ld_s[k] = 1'b0;
            idle_in(k);
            chk_state(k, "reset");
        end
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a stalled write on the 2-cycle instance.
        addr_s[2] = BASE + 32'h10; be_s[2] = 4'hF; wd_s[2] = 32'h55AA55AA; wr_s[2] = 1'b1;
        @(negedge clk);
        chk("abort_wait_first", 32'(wait_s[2]), 32'h1);
        @(posedge clk);
        #1;
        chk("abort_wait_stall", 32'(wait_s[2]), 32'h1);
        #2;
        rst_s[2] = 1'b1;
        #1;
        chk("abort_wait_in_reset", 32'(wait_s[2]), 32'h0);
        chk_state(2, "abort");
        idle_in(2);
        @(posedge clk);
        #1;
        rst_s[2] = 1'b0;
        do_access(2, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, got);
        chk("abort_word_unchanged", got, mm[2][4]);

        // Preloaded word read back with zero stall.
        ld_s[0] = 1'b1; ldaddr_s[0] = 32'hBFC00004; lddata_s[0] = 32'h240ABFC0;
        @(posedge clk);
        #1;
        ld_s[0] = 1'b0;
        mm[0][1] = 32'h240ABFC0;
        do_access(0, 1'b1, 1'b0, 32'hBFC00004, 4'hF, 32'h0, got);
        chk("load_then_read", got, 32'h240ABFC0);
        chk("load_then_read_rdcount", 32'(rdc_s[0]), 32'h1);

        ld_s[0] = 1'b1; ldaddr_s[0] = 32'h00000000; lddata_s[0] = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        ld_s[0] = 1'b0;
        chk("oor_load_no_err", 32'(err_s[0]), 32'h0);

        // 65536 back-to-back reads wrap the counter to its starting value.
        rd_s[0] = 1'b1; addr_s[0] = 32'hBFC00004;
        @(negedge clk);
        chk("wrap_readdata", rdata_s[0], 32'h240ABFC0);
        @(posedge clk);
        repeat (65534) @(posedge clk);
        #1;
        chk("wrap_rdcount_minus1", 32'(rdc_s[0]), 32'(16'(rdm[0] + 65535)));
        @(posedge clk);
        #1;
        idle_in(0);
        rdm[0] += 65536;
        chk_state(0, "wrap");

        for (int i = 0; i < 12; i++) begin
            do_access(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, got);
            chk($sformatf("tbl%0d_readdata", i), got, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(err_s[0]), 32'(tbl[i].exp_err));
        end

        // Byte-lane write with a 3-cycle stall.
        ld_s[1] = 1'b1; ldaddr_s[1] = BASE; lddata_s[1] = 32'h0;
        @(posedge clk);
        #1;
        ld_s[1] = 1'b0;
        mm[1][0] = 32'h0;
        do_access(1, 1'b0, 1'b1, BASE, 4'b0101, 32'hDEADBEEF, got);
        do_access(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, got);
        chk("lane_write_readback", got, 32'h00AD00EF);

        // Request withdrawn mid-stall leaves no trace and the next access stalls fully.
        addr_s[1] = BASE + 32'h4; rd_s[1] = 1'b1;
        @(negedge clk);
        chk("withdraw_wait_first", 32'(wait_s[1]), 32'h1);
        @(posedge clk);
        #1;
        idle_in(1);
        @(negedge clk);
        chk("withdraw_wait_dropped", 32'(wait_s[1]), 32'h0);
        chk("withdraw_readdata", rdata_s[1], 32'h0);
        @(posedge clk);
        #1;
        chk_state(1, "withdraw");
        do_access(1, 1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'h0, got);

        // Load and completing bus write to the same word: load wins, write still counts.
        ld_s[0] = 1'b1; ldaddr_s[0] = 32'hBFC00020; lddata_s[0] = 32'h11111111;
        wr_s[0] = 1'b1; addr_s[0] = 32'hBFC00020; be_s[0] = 4'hF; wd_s[0] = 32'h22222222;
        @(negedge clk);
        chk("collide_wait", 32'(wait_s[0]), 32'h0);
        @(posedge clk);
        #1;
        ld_s[0] = 1'b0;
        idle_in(0);
        mm[0][8] = 32'h11111111;
        wrm[0]++;
        chk_state(0, "collide");
        do_access(0, 1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, got);
        chk("collide_word", got, 32'h11111111);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < ((k == 0) ? 200 : 60); n++) begin
                a = BASE + 32'($urandom_range(0, 255) * 4);
                r = $urandom_range(0, 1);
                w = !r;
                case ($urandom_range(0, 9))
                    0: a = $urandom;
                    1: a = a | 32'($urandom_range(1, 3));
                    2: begin r = 1'b1; w = 1'b1; end
                    3: a = BASE + 32'h400 + 32'($urandom_range(0, 63) * 4);
                    default: ;
                endcase
                do_access(k, r, w, a, 4'($urandom_range(0, 15)), $urandom, got);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_wait_ram.md
AVALON_WAIT_RAM -- requirements
Module: avalon_wait_ram

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the array (power of two, 16..4096).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'hBFC00000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the number of waitrequest stall cycles per access (range 0..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports address, input, 32 bits and byteenable, input, 4 bits: the Avalon byte address and lane enables.
REQ-007 The block SHALL have ports read, input, 1 bit and write, input, 1 bit: the Avalon request strobes.
REQ-008 The block SHALL have ports writedata, input, 32 bits and readdata, output, 32 bits: the Avalon data buses.
REQ-009 The block SHALL have port waitrequest, output, 1 bit: the Avalon stall indication.
REQ-010 The block SHALL have ports load_en, input, 1 bit; load_addr, input, 32 bits; and load_data, input, 32 bits: the bench preload port.
REQ-011 The block SHALL have port err, output, 1 bit: a sticky error flag.
REQ-012 The block SHALL have ports rd_count, output, 16 bits and wr_count, output, 16 bits: completed-access counters.

Function
REQ-013 Word index SHALL be (address - BASE_ADDR) >> 2 (32-bit modular subtraction); an access is in range iff index < DEPTH and address[1:0] == 0.
REQ-014 The FSM SHALL have two states, IDLE and WAIT, plus a 4-bit stall counter cnt.
REQ-015 IDLE with no request SHALL drive waitrequest=0 and remain in IDLE.
REQ-016 In IDLE, if read^write and WAIT_CYCLES==0, waitrequest SHALL be 0 and the access SHALL complete in that cycle.
REQ-017 In IDLE, if read^write and WAIT_CYCLES>0, waitrequest SHALL be 1 and the FSM SHALL go to WAIT with cnt=1 at the next edge.
REQ-018 In WAIT with cnt<WAIT_CYCLES, the block SHALL hold waitrequest=1 and increment cnt.
REQ-019 In WAIT with cnt==WAIT_CYCLES, the block SHALL drive waitrequest=0, complete the access, and return to IDLE.
REQ-020 A request first seen in cycle T SHALL therefore complete in cycle T+WAIT_CYCLES.
REQ-021 Back-to-back requests SHALL each incur a full WAIT_CYCLES stall; cnt never carries between accesses.
REQ-022 waitrequest SHALL be combinational from state, cnt, read, and write; it SHALL be 0 whenever read and write are both 0.
REQ-023 If read and write both drop while in WAIT, the FSM SHALL return to IDLE, clear cnt, and perform no access or count update.
REQ-024 A completing in-range read SHALL present mem[index] combinationally on readdata in the completion cycle.
REQ-025 readdata SHALL be 0 in any cycle that is not a completing in-range read.
REQ-026 A completing in-range write SHALL update only the byte lanes with byteenable[i]=1 at the completion edge; byteenable=0 is a legal no-op write.
REQ-027 Read-during-write SHALL not occur, because the ports are mutually exclusive; a read completing after a write SHALL return the new data.
REQ-028 A completing out-of-range access SHALL return readdata=0, perform no write, and set err.
REQ-029 read and write both high SHALL be treated as an out-of-range access: the stall sequence still runs, then err is set with no side effect.
REQ-030 rd_count and wr_count SHALL increment by 1 at each completing in-range read and write respectively, and wrap from 16'hFFFF to 0.
REQ-031 When load_en=1, load_data SHALL be written as a full word to the word at load_addr at the clock edge, using the mapping in REQ-013.
REQ-032 An out-of-range load SHALL be ignored and SHALL NOT set err.
REQ-033 When load_en and a completing bus write target the same word in the same cycle, the load SHALL win and the bus write SHALL be discarded; wr_count still increments.
REQ-034 The load port SHALL operate while reset is high.

Reset
REQ-035 While reset=1, state=IDLE, cnt=0, err=0, rd_count=0, wr_count=0, waitrequest=0 and readdata=0, asynchronously.
REQ-036 The memory array SHALL NOT be cleared by reset.
REQ-037 Reset asserted mid-WAIT SHALL abort the access with no memory update.

Verification
REQ-038 With WAIT_CYCLES=0: load 32'h240ABFC0 at 32'hBFC00004, then read 32'hBFC00004 -> waitrequest=0 and readdata=32'h240ABFC0 in the same cycle; rd_count=1.
REQ-039 With WAIT_CYCLES=3: write 32'hDEADBEEF at BASE_ADDR with byteenable=4'b0101, word previously 0 -> waitrequest high for 3 cycles, completes on the 4th; readback returns 32'h00AD00EF.
REQ-040 Read of 32'h00000000 and read of BASE_ADDR+2 -> readdata=0, err=1, rd_count unchanged.
REQ-041 With WAIT_CYCLES=2: reset asserted after 1 stall cycle of a write -> err=0, counters 0, word unchanged; the next read takes the full 2-cycle stall.
REQ-042 Simultaneous load (32'h11111111) and completing bus write (32'h22222222) to the same word -> word reads 32'h11111111; wr_count=1.
REQ-043 65536 in-range reads -> rd_count wraps to 0 with err=0.
